// File: rtl/srio_regbank_pkg.sv
// Shared constants, index type, decode classification and byte-enable merge
// helper for the SRIO control register bank.
package srio_regbank_pkg;

  localparam int          ADDR_LSB       = 3;
  localparam logic [3:0]  BASE_NIB_DEF   = 4'hC;
  localparam logic [15:0] COMMIT_OFS_DEF = 16'h00F8;

  // Wide enough for the largest supported bank (64 registers).
  typedef logic [5:0] idx_t;

  typedef enum logic [1:0] {
    DEC_NONE,
    DEC_REG,
    DEC_COMMIT,
    DEC_ERR
  } dec_e;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int k = 0; k < 4; k++) begin
      res[8*k +: 8] = be[k] ? new_val[8*k +: 8] : old_val[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/srio_regbank_lane_merge.sv
// Byte-lane merge of one shadow register with an incoming write payload.
// Lanes whose enable is low keep their current value.
module srio_regbank_lane_merge
  import srio_regbank_pkg::*;
#(
  parameter int REG_W = 32
) (
  input  logic [REG_W-1:0]   cur,
  input  logic [REG_W-1:0]   wdata,
  input  logic [REG_W/8-1:0] be,
  output logic [REG_W-1:0]   merged
);

  logic [31:0] cur_w;
  logic [31:0] wdata_w;
  logic [31:0] merged_w;
  logic [3:0]  be_w;

  // Narrow registers are zero-padded into the 32-bit helper and sliced back.
  always_comb begin
    cur_w                  = '0;
    wdata_w                = '0;
    be_w                   = '0;
    cur_w[REG_W-1:0]       = cur;
    wdata_w[REG_W-1:0]     = wdata;
    be_w[REG_W/8-1:0]      = be;
    merged_w               = be_merge(cur_w, wdata_w, be_w);
  end

  assign merged = merged_w[REG_W-1:0];

endmodule

// File: rtl/srio_ctrl_regbank.sv
// SRIO target-write control register bank: shadow/active registers with
// atomic commit. Optional readback port enabled by SRIO_REGBANK_RDBACK_EN.
module srio_ctrl_regbank
  import srio_regbank_pkg::*;
#(
  parameter int                         NUM_REGS    = 16,
  parameter int                         REG_W       = 32,
  parameter logic [3:0]                 BASE_NIB    = BASE_NIB_DEF,
  parameter logic [15:0]                COMMIT_OFS  = COMMIT_OFS_DEF,
  parameter bit                         AUTO_COMMIT = 1'b0,
  parameter logic [NUM_REGS*REG_W-1:0]  RST_VAL     = '0
) (
  input  logic                          clk,
  input  logic                          sys_rst,
  input  logic                          target_wr,
  input  logic [7:0]                    bus_en_in,
  input  logic [31:0]                   addrin,
  input  logic [63:0]                   din,
  output logic [NUM_REGS*REG_W-1:0]     reg_q,
  output logic [NUM_REGS-1:0]           reg_upd,
  output logic                          commit_pulse,
  output logic                          err_pulse,
  output logic [7:0]                    err_cnt,
  input  logic [$clog2(NUM_REGS)-1:0]   rd_idx,
  input  logic                          rd_req,
  output logic [REG_W-1:0]              rd_data,
  output logic                          rd_vld
);

  localparam int LANES = REG_W / 8;

  // Handshakes: target_wr is a one-beat valid with no backpressure (every
  // asserted cycle is consumed); rd_req is answered by rd_vld exactly one
  // cycle later, also without backpressure.

  logic        s1_wr;
  logic [31:0] s1_addr;
  logic [63:0] s1_din;
  logic [7:0]  s1_be;

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      s1_wr   <= 1'b0;
      s1_addr <= '0;
      s1_din  <= '0;
      s1_be   <= '0;
    end else begin
      s1_wr   <= target_wr;
      s1_addr <= addrin;
      s1_din  <= din;
      s1_be   <= bus_en_in;
    end
  end

  logic [15:0]         off;
  logic                hit;
  dec_e                dec;
  idx_t                wr_idx;
  logic [LANES-1:0]    lane_be;
  logic [REG_W-1:0]    wr_data;
  logic [NUM_REGS-1:0] wr_mask;
  logic                commit_req;
  logic                err_hit;

  always_comb begin
    off        = s1_addr[15:0];
    hit        = s1_wr && (s1_addr[31:28] == BASE_NIB);
    wr_idx     = off[ADDR_LSB +: 6];
    lane_be    = s1_be[4 +: LANES];
    wr_data    = s1_din[32 +: REG_W];
    dec        = DEC_NONE;
    if (hit) begin
      if (off[ADDR_LSB-1:0] == '0 && off[15:ADDR_LSB] < 13'(NUM_REGS)) begin
        dec = DEC_REG;
      end else if (off == COMMIT_OFS) begin
        dec = DEC_COMMIT;
      end else begin
        dec = DEC_ERR;
      end
    end
    // A commit write is still a legal access under auto-commit, it just does nothing.
    commit_req = (dec == DEC_COMMIT) && s1_din[32] && !AUTO_COMMIT;
    err_hit    = (dec == DEC_ERR);
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_mask[i] = (dec == DEC_REG) && (wr_idx == idx_t'(i)) && (|lane_be);
    end
  end

  logic unused_s1;
  assign unused_s1 = ^{s1_addr[27:16], s1_din[31:0], s1_be[3:0]};

  logic [REG_W-1:0] shadow [NUM_REGS];
  logic [REG_W-1:0] active [NUM_REGS];
  logic [REG_W-1:0] merged [NUM_REGS];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_lane
    srio_regbank_lane_merge #(.REG_W(REG_W)) u_merge (
      .cur    (shadow[g]),
      .wdata  (wr_data),
      .be     (lane_be),
      .merged (merged[g])
    );
    assign reg_q[g*REG_W +: REG_W] = active[g];
  end

  logic [NUM_REGS-1:0] dirty;
  logic                s2_commit;
  logic                commit_now;

  assign commit_now = AUTO_COMMIT ? (|dirty) : s2_commit;

  // A write decoded in the same cycle a commit copies the shadows lands after
  // the copy, so it re-arms dirty for the next commit.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= RST_VAL[i*REG_W +: REG_W];
      end
      dirty     <= '0;
      s2_commit <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_mask[i]) begin
          shadow[i] <= merged[i];
        end
      end
      dirty     <= (commit_now ? {NUM_REGS{1'b0}} : dirty) | wr_mask;
      s2_commit <= commit_req;
      err_pulse <= err_hit;
      if (err_hit && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        active[i] <= RST_VAL[i*REG_W +: REG_W];
      end
      reg_upd      <= '0;
      commit_pulse <= 1'b0;
    end else begin
      if (commit_now) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          active[i] <= shadow[i];
        end
      end
      reg_upd      <= commit_now ? dirty : {NUM_REGS{1'b0}};
      commit_pulse <= commit_now;
    end
  end

`ifdef SRIO_REGBANK_RDBACK_EN
  // Reads the active array before any same-cycle commit lands.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      rd_data <= '0;
      rd_vld  <= 1'b0;
    end else begin
      rd_vld <= rd_req;
      if (rd_req && 32'(rd_idx) < NUM_REGS) begin
        rd_data <= active[rd_idx];
      end else begin
        rd_data <= '0;
      end
    end
  end
`else
  assign rd_data = '0;
  assign rd_vld  = 1'b0;

  logic unused_rd;
  assign unused_rd = ^{rd_idx, rd_req};
`endif

endmodule

// File: tb/tb_srio_ctrl_regbank.sv
// Self-checking bench for srio_ctrl_regbank: transaction-level model compared
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_srio_ctrl_regbank;

  localparam int NR = 16;
  localparam int RW = 32;

  logic          clk       = 1'b0;
  logic          sys_rst   = 1'b1;
  logic          target_wr = 1'b0;
  logic [7:0]    bus_en_in = '0;
  logic [31:0]   addrin    = '0;
  logic [63:0]   din       = '0;
  logic [NR*RW-1:0] reg_q;
  logic [NR-1:0] reg_upd;
  logic          commit_pulse;
  logic          err_pulse;
  logic [7:0]    err_cnt;
  logic [3:0]    rd_idx    = '0;
  logic          rd_req    = 1'b0;
  logic [RW-1:0] rd_data;
  logic          rd_vld;

  // Clock / reset
  always #5 clk = ~clk;

  srio_ctrl_regbank dut (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .target_wr    (target_wr),
    .bus_en_in    (bus_en_in),
    .addrin       (addrin),
    .din          (din),
    .reg_q        (reg_q),
    .reg_upd      (reg_upd),
    .commit_pulse (commit_pulse),
    .err_pulse    (err_pulse),
    .err_cnt      (err_cnt),
    .rd_idx       (rd_idx),
    .rd_req       (rd_req),
    .rd_data      (rd_data),
    .rd_vld       (rd_vld)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit done    = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural model: a beat's register/error effect lands two edges after
  // it is driven, a commit copies shadows one edge after that.
  logic [31:0] m_shadow [NR];
  logic [31:0] m_active [NR];
  logic [15:0] m_dirty;
  logic [7:0]  m_err_cnt;
  logic [15:0] e_upd;
  logic        e_commit, e_err, e_rd_vld;
  logic [31:0] e_rd_data;
  logic        d1_wr;
  logic [31:0] d1_addr;
  logic [63:0] d1_din;
  logic [7:0]  d1_be;
  logic        pend_commit;
  logic        model_live = 1'b0;

  always @(posedge clk) begin
    logic        next_commit;
    logic [15:0] off;
    int          idx;
    model_live  = 1'b1;
    next_commit = 1'b0;
    if (sys_rst) begin
      for (int i = 0; i < NR; i++) begin
        m_shadow[i] = '0;
        m_active[i] = '0;
      end
      m_dirty = '0; m_err_cnt = '0;
      e_upd = '0; e_commit = 0; e_err = 0; e_rd_vld = 0; e_rd_data = '0;
      d1_wr = 0; d1_addr = '0; d1_din = '0; d1_be = '0; pend_commit = 0;
    end else begin
      e_rd_vld  = 1'b0;
      e_rd_data = '0;
`ifdef SRIO_REGBANK_RDBACK_EN
      if (rd_req) begin
        e_rd_vld  = 1'b1;
        e_rd_data = (int'(rd_idx) < NR) ? m_active[rd_idx] : 32'h0;
      end
`endif
      e_upd = '0; e_commit = 1'b0; e_err = 1'b0;
      if (pend_commit) begin
        for (int i = 0; i < NR; i++) m_active[i] = m_shadow[i];
        e_upd    = m_dirty;
        m_dirty  = '0;
        e_commit = 1'b1;
      end
      if (d1_wr && d1_addr[31:28] == 4'hC) begin
        off = d1_addr[15:0];
        if (off % 8 == 0 && off / 8 < NR) begin
          idx = off / 8;
          if (d1_be[7:4] != 4'h0) begin
            for (int k = 0; k < 4; k++)
              if (d1_be[4+k]) m_shadow[idx][8*k +: 8] = d1_din[32+8*k +: 8];
            m_dirty[idx] = 1'b1;
          end
        end else if (off == 16'h00F8) begin
          next_commit = d1_din[32];
        end else begin
          e_err = 1'b1;
          if (m_err_cnt != 8'hFF) m_err_cnt = m_err_cnt + 8'd1;
        end
      end
      pend_commit = next_commit;
      d1_wr = target_wr; d1_addr = addrin; d1_din = din; d1_be = bus_en_in;
    end
  end

  // Scoreboard: per-cycle compare plus a queue of reg_upd values seen on commits.
  logic [15:0]      upd_q[$];
  logic [NR*RW-1:0] e_regs;

  always @(negedge clk) begin
    if (model_live && !done) begin
      for (int i = 0; i < NR; i++) e_regs[i*RW +: RW] = m_active[i];
      check("reg_q", reg_q, e_regs);
      check("reg_upd", reg_upd, e_upd);
      check("commit_pulse", commit_pulse, e_commit);
      check("err_pulse", err_pulse, e_err);
      check("err_cnt", err_cnt, m_err_cnt);
      check("rd_vld", rd_vld, e_rd_vld);
      check("rd_data", rd_data, e_rd_data);
      if (commit_pulse === 1'b1) upd_q.push_back(reg_upd);
    end
  end

  // Driver tasks (called at a negedge, return at the next negedge)
  task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic [7:0] be);
    target_wr = 1'b1; addrin = a; din = {d, 32'h0}; bus_en_in = be;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    target_wr = 1'b0; addrin = '0; din = '0; bus_en_in = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic commit();
    beat(32'hC000_00F8, 32'h0000_0001, 8'hF0);
  endtask

  task automatic expect_upd(input string name, input logic [15:0] e);
    if (upd_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: no commit seen, required reg_upd %0h", name, e);
    end else begin
      check(name, upd_q.pop_front(), e);
    end
  endtask

  task automatic readback(input logic [3:0] idx);
    rd_idx = idx; rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    // 1: reset state
    check("rst_reg_q", reg_q, '0);
    check("rst_err_cnt", err_cnt, 8'h00);
    check("rst_pulses", {reg_upd, commit_pulse, err_pulse, rd_vld}, '0);
    sys_rst = 1'b0;
    idle(2);

    // 2: byte merge over two commits
    upd_q.delete();
    beat(32'hC000_0008, 32'hAABB_CCDD, 8'hF0);
    commit();
    idle(4);
    check("t2_reg1_first", reg_q[1*RW +: RW], 32'hAABB_CCDD);
    expect_upd("t2_upd_first", 16'h0002);
    beat(32'hC000_0008, 32'h1122_3344, 8'h30);
    commit();
    idle(4);
    check("t2_reg1_merge", reg_q[1*RW +: RW], 32'hAABB_3344);
    expect_upd("t2_upd_second", 16'h0002);
    readback(4'd1);
`ifdef SRIO_REGBANK_RDBACK_EN
    check("t2_rd_data", rd_data, 32'hAABB_3344);
    check("t2_rd_vld", rd_vld, 1'b1);
`else
    check("t2_rd_data", rd_data, 32'h0);
    check("t2_rd_vld", rd_vld, 1'b0);
`endif
    idle(2);

    // 3: two writes held in shadow until one commit
    beat(32'hC000_0010, 32'h1234_5678, 8'hF0);
    beat(32'hC000_0028, 32'h9ABC_DEF0, 8'hF0);
    idle(4);
    check("t3_reg2_held", reg_q[2*RW +: RW], 32'h0);
    check("t3_reg5_held", reg_q[5*RW +: RW], 32'h0);
    commit();
    idle(4);
    check("t3_reg2", reg_q[2*RW +: RW], 32'h1234_5678);
    check("t3_reg5", reg_q[5*RW +: RW], 32'h9ABC_DEF0);
    expect_upd("t3_upd", 16'h0024);

    // 4: write immediately followed by commit
    beat(32'hC000_0000, 32'hCAFE_F00D, 8'hF0);
    commit();
    idle(4);
    check("t4_reg0", reg_q[0 +: RW], 32'hCAFE_F00D);
    expect_upd("t4_upd", 16'h0001);

    // addr[27:16] ignored, commit with din[32]=0 is a silent no-op
    beat(32'hC123_0030, 32'h5566_7788, 8'hF0);
    beat(32'hC000_00F8, 32'h0000_0000, 8'hF0);
    idle(4);
    check("noop_commit", upd_q.size(), 0);
    commit();
    idle(4);
    check("mid_addr_reg6", reg_q[6*RW +: RW], 32'h5566_7788);
    expect_upd("mid_addr_upd", 16'h0040);

    // zero byte enables: no change, not dirty
    beat(32'hC000_0018, 32'hDEAD_BEEF, 8'h00);
    commit();
    idle(4);
    check("be0_reg3", reg_q[3*RW +: RW], 32'h0);
    expect_upd("be0_upd", 16'h0000);

    // write landing as a commit takes effect belongs to the next commit
    commit();
    beat(32'hC000_0018, 32'h0BAD_CAFE, 8'hF0);
    idle(4);
    check("late_reg3_held", reg_q[3*RW +: RW], 32'h0);
    expect_upd("late_upd_first", 16'h0000);
    commit();
    idle(4);
    check("late_reg3", reg_q[3*RW +: RW], 32'h0BAD_CAFE);
    expect_upd("late_upd_second", 16'h0008);

    // 5: errors and saturation, out-of-window ignored
    beat(32'hC000_0080, 32'h1111_1111, 8'hF0);
    idle(3);
    check("t5_err_one", err_cnt, 8'h01);
    for (int i = 0; i < 300; i++) beat(32'hC000_0004, 32'h2222_2222, 8'hF0);
    idle(3);
    check("t5_err_sat", err_cnt, 8'hFF);
    beat(32'hB000_0000, 32'h3333_3333, 8'hF0);
    commit();
    idle(4);
    check("t5_miss_reg0", reg_q[0 +: RW], 32'hCAFE_F00D);
    expect_upd("t5_miss_upd", 16'h0000);

    // 6: reset one cycle after a write discards it
    beat(32'hC000_0038, 32'h7777_7777, 8'hF0);
    target_wr = 1'b0; sys_rst = 1'b1;
    @(negedge clk);
    sys_rst = 1'b0;
    idle(3);
    check("t6_reg_q", reg_q, '0);
    check("t6_err_cnt", err_cnt, 8'h00);
    commit();
    idle(4);
    check("t6_reg7", reg_q[7*RW +: RW], 32'h0);
    readback(4'd1);
`ifdef SRIO_REGBANK_RDBACK_EN
    check("t6_rd_vld", rd_vld, 1'b1);
`else
    check("t6_rd_vld", rd_vld, 1'b0);
`endif
    check("t6_rd_data", rd_data, 32'h0);
    idle(2);

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
